// File: rtl/lcd4_ctrl.sv
// HD44780 4-bit write-only controller: power-up wait, fixed init sequence, then one byte per in_valid/in_ready handshake.
// Latency: SETUP begins the cycle after acceptance. in_ready is high only in IDLE after init; offers made while busy are dropped, not queued.
module lcd4_ctrl #(
    parameter int PWRUP_CYC      = 3000000,
    parameter int SETUP_CYC      = 10,
    parameter int E_PULSE_CYC    = 50,
    parameter int HOLD_CYC       = 10,
    parameter int GAP_CYC        = 200,
    parameter int CMD_WAIT_CYC   = 8000,
    parameter int CLR_WAIT_CYC   = 328000,
    parameter int INIT_WAIT1_CYC = 820000,
    parameter int INIT_WAIT2_CYC = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       init_done,
    output logic       busy,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_E,
    output logic [3:0] LCD_D
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAXC = max2(max2(max2(PWRUP_CYC, SETUP_CYC), max2(E_PULSE_CYC, HOLD_CYC)),
                               max2(max2(GAP_CYC, CMD_WAIT_CYC),
                                    max2(CLR_WAIT_CYC, max2(INIT_WAIT1_CYC, INIT_WAIT2_CYC))));
    localparam int CW = $clog2(MAXC + 1);

    typedef logic [CW-1:0] cnt_t;
    typedef enum logic [2:0] {PWR, SETUP, EHI, HOLD, GAP, WAIT, IDLE} state_t;

    // A state lasting n cycles is entered with n-1 loaded and left on the cycle the counter reads zero.
    function automatic cnt_t ld(input int n);
        return (n > 0) ? cnt_t'(n - 1) : '0;
    endfunction

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h28;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    state_t     state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic       arm_q, arm_d;
    logic [2:0] step_q, step_d;
    logic       init_done_q, init_done_d;
    logic       rs_q, rs_d;
    logic [3:0] d_q, d_d;
    logic [7:0] byte_q, byte_d;
    logic       lo_q, lo_d;
    logic       single_q, single_d;
    logic       e_q;

    logic       cnt_zero;
    logic       start_setup;
    logic [3:0] setup_nib;
    logic [2:0] step_nx;
    logic [7:0] ib;
    cnt_t       wait_ld;

    assign cnt_zero  = (cnt_q == '0);
    assign in_ready  = (state_q == IDLE) && init_done_q;
    assign busy      = (state_q != IDLE);
    assign init_done = init_done_q;
    assign LCD_RS    = rs_q;
    assign LCD_D     = d_q;
    assign LCD_E     = e_q;
    assign LCD_RW    = 1'b0;

    // Init steps 0-2 wait progressively shorter; clear/home commands (0x01-0x03, RS=0) need the long wait.
    always_comb begin
        wait_ld = ld(CMD_WAIT_CYC);
        if (single_q) begin
            if (step_q == 3'd0) begin
                wait_ld = ld(INIT_WAIT1_CYC);
            end else if (step_q == 3'd1) begin
                wait_ld = ld(INIT_WAIT2_CYC);
            end
        end else if (!rs_q && (byte_q[7:2] == 6'd0) && (byte_q[1:0] != 2'd0)) begin
            wait_ld = ld(CLR_WAIT_CYC);
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        arm_d       = arm_q;
        step_d      = step_q;
        init_done_d = init_done_q;
        rs_d        = rs_q;
        d_d         = d_q;
        byte_d      = byte_q;
        lo_d        = lo_q;
        single_d    = single_q;
        start_setup = 1'b0;
        setup_nib   = d_q;
        step_nx     = step_q + 3'd1;
        ib          = init_byte(step_nx[1:0]);

        case (state_q)
            PWR: begin
                if (!arm_q && (PWRUP_CYC > 1)) begin
                    arm_d = 1'b1;
                    cnt_d = ld(PWRUP_CYC - 1);
                end else if (cnt_zero) begin
                    arm_d       = 1'b1;
                    start_setup = 1'b1;
                    setup_nib   = 4'h3;
                    rs_d        = 1'b0;
                    single_d    = 1'b1;
                    lo_d        = 1'b0;
                    step_d      = 3'd0;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    state_d = EHI;
                    cnt_d   = ld(E_PULSE_CYC);
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            EHI: begin
                if (cnt_zero) begin
                    state_d = HOLD;
                    cnt_d   = ld(HOLD_CYC);
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            HOLD: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - cnt_t'(1);
                end else if (single_q || lo_q) begin
                    state_d = WAIT;
                    cnt_d   = wait_ld;
                end else begin
                    state_d = GAP;
                    cnt_d   = ld(GAP_CYC);
                end
            end
            GAP: begin
                if (cnt_zero) begin
                    start_setup = 1'b1;
                    setup_nib   = byte_q[3:0];
                    lo_d        = 1'b1;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            WAIT: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - cnt_t'(1);
                end else if (init_done_q) begin
                    state_d = IDLE;
                end else if (step_q == 3'd7) begin
                    init_done_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    step_d      = step_nx;
                    start_setup = 1'b1;
                    rs_d        = 1'b0;
                    lo_d        = 1'b0;
                    if (!step_nx[2]) begin
                        single_d  = 1'b1;
                        setup_nib = (step_nx == 3'd3) ? 4'h2 : 4'h3;
                    end else begin
                        single_d  = 1'b0;
                        byte_d    = ib;
                        setup_nib = ib[7:4];
                    end
                end
            end
            IDLE: begin
                if (in_valid && in_ready) begin
                    byte_d      = in_data;
                    rs_d        = in_rs;
                    start_setup = 1'b1;
                    setup_nib   = in_data[7:4];
                    single_d    = 1'b0;
                    lo_d        = 1'b0;
                end
            end
            default: state_d = PWR;
        endcase

        // RS/D are only ever updated here, so they stay frozen through EHI.
        if (start_setup) begin
            state_d = SETUP;
            cnt_d   = ld(SETUP_CYC);
            d_d     = setup_nib;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PWR;
            cnt_q       <= '0;
            arm_q       <= 1'b0;
            step_q      <= 3'd0;
            init_done_q <= 1'b0;
            rs_q        <= 1'b0;
            d_q         <= 4'h0;
            byte_q      <= 8'h00;
            lo_q        <= 1'b0;
            single_q    <= 1'b0;
            e_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            arm_q       <= arm_d;
            step_q      <= step_d;
            init_done_q <= init_done_d;
            rs_q        <= rs_d;
            d_q         <= d_d;
            byte_q      <= byte_d;
            lo_q        <= lo_d;
            single_q    <= single_d;
            e_q         <= (state_d == EHI);
        end
    end

endmodule

// File: tb/tb_lcd4_ctrl.sv
// Bench for lcd4_ctrl: a queue of expected per-cycle bus values built from transfer timing rules, compared every cycle.
module tb_lcd4_ctrl;

    localparam int P_PWR = 20, P_SETUP = 2, P_E = 4, P_HOLD = 2, P_GAP = 3;
    localparam int P_CMD = 10, P_CLR = 40, P_IW1 = 30, P_IW2 = 10;
    localparam int INIT_CYCLES = 258;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_rs;
    logic [7:0] in_data;
    logic       in_ready, init_done, busy;
    logic       LCD_RS, LCD_RW, LCD_E;
    logic [3:0] LCD_D;

    lcd4_ctrl #(
        .PWRUP_CYC(P_PWR), .SETUP_CYC(P_SETUP), .E_PULSE_CYC(P_E), .HOLD_CYC(P_HOLD),
        .GAP_CYC(P_GAP), .CMD_WAIT_CYC(P_CMD), .CLR_WAIT_CYC(P_CLR),
        .INIT_WAIT1_CYC(P_IW1), .INIT_WAIT2_CYC(P_IW2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_rs(in_rs),
        .in_data(in_data), .init_done(init_done), .busy(busy), .LCD_RS(LCD_RS),
        .LCD_RW(LCD_RW), .LCD_E(LCD_E), .LCD_D(LCD_D)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       e;
        logic       rs;
        logic [3:0] d;
        logic       busy;
        logic       rdy;
        logic       idone;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] pulse_d[$];
    logic       pulse_rs[$];
    bit         idone_m;
    logic       m_rs;
    logic [3:0] m_d;
    int         cyc, first_rdy, last_fall, last_gap;
    bit         prev_e;
    logic       prev_rs;
    logic [3:0] prev_d;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push_n(input int n, input bit e, input logic rs, input logic [3:0] d);
        exp_t x;
        x.e = e; x.rs = rs; x.d = d; x.busy = 1'b1; x.rdy = 1'b0; x.idone = idone_m;
        for (int i = 0; i < n; i++) exp_q.push_back(x);
        m_rs = rs;
        m_d  = d;
    endtask

    task automatic push_nib(input logic rs, input logic [3:0] nib);
        push_n(P_SETUP, 1'b0, rs, nib);
        push_n(P_E, 1'b1, rs, nib);
        push_n(P_HOLD, 1'b0, rs, nib);
    endtask

    task automatic push_byte(input logic rs, input logic [7:0] b);
        bit is_clr;
        is_clr = (rs == 1'b0) && (b >= 8'd1) && (b <= 8'd3);
        push_nib(rs, b[7:4]);
        push_n(P_GAP, 1'b0, rs, b[7:4]);
        push_nib(rs, b[3:0]);
        push_n(is_clr ? P_CLR : P_CMD, 1'b0, rs, b[3:0]);
    endtask

    task automatic model_reset();
        exp_q.delete(); pulse_d.delete(); pulse_rs.delete();
        idone_m = 1'b0; m_rs = 1'b0; m_d = 4'h0;
        prev_e = 1'b0; prev_rs = 1'b0; prev_d = 4'h0;
        first_rdy = -1; last_fall = 0; last_gap = 0;
        push_n(P_PWR, 1'b0, 1'b0, 4'h0);
        push_nib(1'b0, 4'h3); push_n(P_IW1, 1'b0, 1'b0, 4'h3);
        push_nib(1'b0, 4'h3); push_n(P_IW2, 1'b0, 1'b0, 4'h3);
        push_nib(1'b0, 4'h3); push_n(P_CMD, 1'b0, 1'b0, 4'h3);
        push_nib(1'b0, 4'h2); push_n(P_CMD, 1'b0, 1'b0, 4'h2);
        push_byte(1'b0, 8'h28);
        push_byte(1'b0, 8'h0C);
        push_byte(1'b0, 8'h06);
        push_byte(1'b0, 8'h01);
        idone_m = 1'b1;
    endtask

    // Called at a falling edge: compare this cycle, drive inputs for the next rising edge.
    task automatic tick(input bit v, input logic rs, input logic [7:0] dat, output bit acc);
        exp_t ex;
        bit   idle;
        idle = (exp_q.size() == 0);
        if (idle) begin
            ex.e = 1'b0; ex.rs = m_rs; ex.d = m_d; ex.busy = 1'b0; ex.rdy = idone_m; ex.idone = idone_m;
        end else begin
            ex = exp_q.pop_front();
        end
        check_eq("cycle_outputs{E,RS,D,busy,rdy,done,RW}",
                 {22'd0, LCD_E, LCD_RS, LCD_D, busy, in_ready, init_done, LCD_RW},
                 {22'd0, ex.e, ex.rs, ex.d, ex.busy, ex.rdy, ex.idone, 1'b0});
        if (prev_e && LCD_E) check_eq("rs_d_stable_while_e", {LCD_RS, LCD_D}, {prev_rs, prev_d});
        if (LCD_E && !prev_e) begin
            pulse_d.push_back(LCD_D);
            pulse_rs.push_back(LCD_RS);
            last_gap = cyc - last_fall;
        end
        if (!LCD_E && prev_e) last_fall = cyc;
        if (in_ready && first_rdy < 0) first_rdy = cyc;
        prev_e = LCD_E; prev_rs = LCD_RS; prev_d = LCD_D;
        in_valid = v; in_rs = rs; in_data = dat;
        acc = 1'b0;
        if (idle && idone_m && v) begin
            push_byte(rs, dat);
            acc = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_ready(input int limit);
        bit a;
        int n;
        n = 0;
        while (!in_ready && n < limit) begin
            tick(1'b0, 1'b0, 8'h00, a);
            n++;
        end
        check_eq("ready_within_bound", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic release_and_init();
        logic [3:0] init_seq [12];
        bit a;
        init_seq = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'hC, 4'h0, 4'h6, 4'h0, 4'h1};
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        cyc = 0;
        // Requester offers continuously through init; nothing may be taken early.
        for (int i = 0; i < INIT_CYCLES; i++) tick(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), a);
        check_eq("init_pulse_count", pulse_d.size(), 12);
        for (int i = 0; i < 12 && i < pulse_d.size(); i++) begin
            check_eq($sformatf("init_nibble_%0d", i), {28'd0, pulse_d[i]}, {28'd0, init_seq[i]});
            check_eq($sformatf("init_rs_%0d", i), {31'd0, pulse_rs[i]}, 32'd0);
        end
        check_eq("no_ready_before_init_end", first_rdy, -1);
        check_eq("init_done_at_258", {31'd0, init_done}, 32'd1);
        check_eq("ready_at_258", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic send(input logic rs, input logic [7:0] b, input int exp_dur, input string nm);
        bit a;
        int k;
        wait_ready(300);
        k = cyc;
        tick(1'b1, rs, b, a);
        check_eq({nm, "_ready_drops"}, {31'd0, in_ready}, 32'd0);
        wait_ready(200);
        check_eq({nm, "_busy_cycles"}, cyc - k, exp_dur);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        bit a;
        int n;
        cyc = 0;
        rst_n = 1'b0; in_valid = 1'b1; in_rs = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_E", {31'd0, LCD_E}, 32'd0);
        check_eq("rst_RS", {31'd0, LCD_RS}, 32'd0);
        check_eq("rst_D", {28'd0, LCD_D}, 32'd0);
        check_eq("rst_ready", {31'd0, in_ready}, 32'd0);
        check_eq("rst_done", {31'd0, init_done}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd1);
        check_eq("rst_RW", {31'd0, LCD_RW}, 32'd0);

        release_and_init();

        send(1'b1, 8'h41, 30, "data_0x41");
        check_eq("0x41_hi_nibble", {28'd0, pulse_d[pulse_d.size()-2]}, 32'h4);
        check_eq("0x41_lo_nibble", {28'd0, pulse_d[pulse_d.size()-1]}, 32'h1);
        check_eq("0x41_rs", {31'd0, pulse_rs[pulse_rs.size()-1]}, 32'd1);
        check_eq("0x41_e_low_between_nibbles", last_gap, P_HOLD + P_GAP + P_SETUP);
        send(1'b0, 8'h01, 60, "cmd_0x01");
        send(1'b0, 8'h80, 30, "cmd_0x80");
        send(1'b1, 8'h02, 30, "data_0x02");

        for (int i = 0; i < 1500; i++) begin
            logic [7:0] dd;
            dd = 8'($urandom);
            if ($urandom_range(0, 3) == 0) dd = 8'($urandom_range(0, 3));
            tick($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), dd, a);
        end

        wait_ready(300);
        tick(1'b1, 1'b0, 8'h28, a);
        n = 0;
        while (!LCD_E && n < 50) begin
            tick(1'b0, 1'b0, 8'h00, a);
            n++;
        end
        check_eq("e_high_before_reset", {31'd0, LCD_E}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("async_rst_E", {31'd0, LCD_E}, 32'd0);
        check_eq("async_rst_done", {31'd0, init_done}, 32'd0);
        check_eq("async_rst_busy", {31'd0, busy}, 32'd1);
        check_eq("async_rst_ready", {31'd0, in_ready}, 32'd0);
        check_eq("async_rst_RS_D", {27'd0, LCD_RS, LCD_D}, 32'd0);
        repeat (3) @(posedge clk);
        release_and_init();
        send(1'b0, 8'h03, 60, "cmd_0x03_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
